log_unit: RTL and testbench

LOG_UNIT -- requirements
Module: log_unit

---
 rtl/log_unit.sv | 216 +++++++++++++++++++++
 tb/tb_log_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/log_unit.sv
// Fixed-point logarithm (log2 / ln / log10) of an unsigned operand, one result at a time.
// Latency: handshake at edge k -> out_valid after edge k+OUT_FRAC+2, independent of data and mode.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready, then back to IDLE.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   I_RST      synchronous active-high reset
//   in_valid   / in_ready   operand handshake (in_data unsigned, IN_FRAC fractional bits;
//                           in_mode 0=log2, 1=ln, 2=log10, 3=log2)
//   out_valid  / out_ready  result handshake (out_data signed, OUT_FRAC fractional bits)
//   out_err    operand was zero (out_data = most negative value)
//   out_sat    result was clamped to the signed OUT_W range
module log_unit #(
  parameter int IN_W     = 24,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8,
  parameter int M_W      = 16
) (
  input  logic                 clk,
  input  logic                 I_RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_err,
  output logic                 out_sat
);

  localparam int MSB_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  // e spans -IN_FRAC .. IN_W-1-IN_FRAC; one extra bit of headroom beyond the sign
  localparam int E_W   = MSB_W + 2;
  localparam int L_W   = E_W + OUT_FRAC;
  // wide enough that L * 17-bit constant never overflows and clamping compares are exact
  localparam int R_W   = L_W + OUT_W + 20;
  localparam int CNT_W = $clog2(OUT_FRAC + 1);

  localparam logic signed [R_W-1:0] MAX_V = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] MIN_V = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    ITER  = 3'd2,
    SCALE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic [IN_W-1:0]         r_x;
  logic [1:0]              r_mode;
  logic signed [E_W-1:0]   r_e;
  logic [M_W:0]            r_m;       // 1.M_W unsigned mantissa in [1,2)
  logic [OUT_FRAC-1:0]     r_frac;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_zero;
  logic [OUT_W-1:0]        r_data;
  logic                    r_err;
  logic                    r_sat;

  // ---------------- normalisation ----------------
  logic [MSB_W-1:0]        w_msb;
  logic [MSB_W-1:0]        w_shamt;
  logic [IN_W-1:0]         w_aligned;
  logic [IN_W+M_W-1:0]     w_ext;
  logic [M_W:0]            w_mant;
  logic signed [E_W-1:0]   w_e;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (r_x[i]) w_msb = MSB_W'(i);
    end
  end

  assign w_shamt   = MSB_W'(IN_W - 1) - w_msb;
  assign w_aligned = r_x << w_shamt;
  // Pad below the aligned word so the mantissa works for IN_W-1 either above or below M_W;
  // the top M_W+1 bits are the 1.f mantissa, lower bits are truncated away.
  assign w_ext     = {w_aligned, {M_W{1'b0}}};
  assign w_mant    = (M_W+1)'(w_ext >> (IN_W - 1));
  assign w_e       = $signed(E_W'(w_msb)) - $signed(E_W'(IN_FRAC));

  // ---------------- iteration ----------------
  logic [2*M_W+1:0]        w_sq;
  logic [M_W+1:0]          w_sq_t;    // m*m truncated to M_W fraction bits, range [1,4)
  logic                    w_bit;
  logic [M_W:0]            w_m_next;

  assign w_sq     = r_m * r_m;
  assign w_sq_t   = (M_W+2)'(w_sq >> M_W);
  assign w_bit    = w_sq_t[M_W+1];
  assign w_m_next = w_bit ? w_sq_t[M_W+1:1] : w_sq_t[M_W:0];

  // ---------------- scaling and clamp ----------------
  logic signed [L_W-1:0]   w_l;
  logic signed [R_W-1:0]   w_lx;
  logic signed [R_W-1:0]   w_k;
  logic signed [R_W-1:0]   w_p;
  logic signed [R_W-1:0]   w_res;
  logic                    w_hi;
  logic                    w_lo;

  // e is signed, so the concatenation equals e*2^OUT_FRAC + fraction
  assign w_l  = $signed({r_e, r_frac});
  assign w_lx = w_l;

  always_comb begin
    w_k = '0;
    case (r_mode)
      2'd1:    w_k = R_W'(45426);   // ln(2)     in Q16
      2'd2:    w_k = R_W'(19728);   // log10(2)  in Q16
      default: w_k = '0;
    endcase
  end

  assign w_p   = w_lx * w_k;
  assign w_res = ((r_mode == 2'd1) || (r_mode == 2'd2)) ? (w_p >>> 16) : w_lx;
  assign w_hi  = (w_res > MAX_V);
  assign w_lo  = (w_res < MIN_V);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (I_RST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = NORM;
      end
      NORM:  w_next = ITER;
      ITER: begin
        if (r_cnt == CNT_W'(OUT_FRAC - 1)) w_next = SCALE;
      end
      SCALE: w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (I_RST) begin
      r_x    <= '0;
      r_mode <= '0;
      r_e    <= '0;
      r_m    <= '0;
      r_frac <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x    <= in_data;
            r_mode <= in_mode;
          end
        end
        NORM: begin
          r_e    <= w_e;
          r_m    <= w_mant;
          r_zero <= (r_x == '0);
          r_frac <= '0;
          r_cnt  <= '0;
        end
        ITER: begin
          r_m    <= w_m_next;
          r_frac <= (r_frac << 1) | OUT_FRAC'(w_bit);
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        SCALE: begin
          if (r_zero) begin
            r_data <= {1'b1, {(OUT_W-1){1'b0}}};
            r_err  <= 1'b1;
            r_sat  <= 1'b0;
          end else if (w_hi) begin
            r_data <= MAX_V[OUT_W-1:0];
            r_err  <= 1'b0;
            r_sat  <= 1'b1;
          end else if (w_lo) begin
            r_data <= MIN_V[OUT_W-1:0];
            r_err  <= 1'b0;
            r_sat  <= 1'b1;
          end else begin
            r_data <= w_res[OUT_W-1:0];
            r_err  <= 1'b0;
            r_sat  <= 1'b0;
          end
        end
        default: ;  // DONE holds the result stable
      endcase
    end
  end

  assign out_data = r_data;
  assign out_err  = r_err;
  assign out_sat  = r_sat;

endmodule

// File: tb/tb_log_unit.sv
// Self-checking bench for log_unit: default instance plus a narrow (16-in / 8-out) instance.
// Latency: each operation is timed from input handshake to out_valid.
// Backpressure: out_ready held low for a few cycles on selected operations.
module tb_log_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // default-parameter instance
  logic        iv1, ir1, ov1, or1, oe1, os1;
  logic [23:0] id1;
  logic [1:0]  im1;
  logic [15:0] od1;

  // IN_W=16, IN_FRAC=0, OUT_W=8, OUT_FRAC=4
  logic        iv2, ir2, ov2, or2, oe2, os2;
  logic [15:0] id2;
  logic [1:0]  im2;
  logic [7:0]  od2;

  log_unit dut (
    .clk(clk), .I_RST(rst),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_mode(im1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_err(oe1), .out_sat(os1)
  );

  log_unit #(.IN_W(16), .IN_FRAC(0), .OUT_W(8), .OUT_FRAC(4)) dut2 (
    .clk(clk), .I_RST(rst),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_mode(im2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_err(oe2), .out_sat(os2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        e;
    logic        s;
  } exp_t;
  exp_t sb[$];

  // which instance the driver talks to
  logic        sel;
  logic        m_ir, m_ov, m_oe, m_os;
  logic [15:0] m_od;

  always_comb begin
    if (sel) begin
      m_ir = ir2; m_ov = ov2; m_oe = oe2; m_os = os2; m_od = {8'h00, od2};
    end else begin
      m_ir = ir1; m_ov = ov1; m_oe = oe1; m_os = os1; m_od = od1;
    end
  end

  task automatic set_in(input logic v, input logic [23:0] d, input logic [1:0] m);
    if (sel) begin
      iv2 = v; id2 = d[15:0]; im2 = m;
    end else begin
      iv1 = v; id1 = d; im1 = m;
    end
  endtask

  task automatic set_ordy(input logic r);
    if (sel) or2 = r;
    else     or1 = r;
  endtask

  // Drive one operand, then scoreboard the result; junk data with in_valid=1 is driven
  // while busy to show it is neither captured nor allowed to disturb the operation.
  task automatic do_op(input string tag, input logic [23:0] x, input logic [1:0] mode,
                       input logic [15:0] ed, input logic ee, input logic es, input int hold);
    exp_t t;
    int   lat;
    int   exp_lat;
    bit   seen;
    exp_lat = sel ? 6 : 10;
    t.d = ed; t.e = ee; t.s = es;
    sb.push_back(t);
    @(negedge clk);
    check({tag, "_in_rdy"}, 32'(m_ir), 32'd1);
    set_in(1'b1, x, mode);
    @(posedge clk); #1;
    set_in(1'b1, ~x, ~mode);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (m_ov) seen = 1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (seen) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check({tag, "_hold_dat"}, 32'(m_od), 32'(sb[0].d));
        check({tag, "_hold_rdy"}, 32'({m_ov, m_ir}), 32'b10);
      end
      set_in(1'b0, 24'h0, 2'd0);
      set_ordy(1'b1);
      t = sb.pop_front();
      check({tag, "_dat"}, 32'(m_od), 32'(t.d));
      check({tag, "_err"}, 32'(m_oe), 32'(t.e));
      check({tag, "_sat"}, 32'(m_os), 32'(t.s));
      @(posedge clk); #1;
      set_ordy(1'b0);
      check({tag, "_idle"}, 32'({m_ov, m_ir}), 32'b01);
    end else begin
      set_in(1'b0, 24'h0, 2'd0);
      void'(sb.pop_front());
    end
  endtask

  // expected log of 2^n at default parameters, straight from the scaling formula
  function automatic logic [15:0] pow2_exp(input int n, input logic [1:0] mode);
    longint l;
    l = longint'(n - 8) * 256;
    if (mode == 2'd1)      l = (l * 45426) >>> 16;
    else if (mode == 2'd2) l = (l * 19728) >>> 16;
    return 16'(l);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    iv1 = 1'b1; id1 = 24'h000200; im1 = 2'd0; or1 = 1'b0;  // in_valid held during reset
    iv2 = 1'b1; id2 = 16'h0004;   im2 = 2'd0; or2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy",  32'(ir1), 32'd1);
    check("rst_out_vld", 32'(ov1), 32'd0);
    check("rst_out_dat", 32'(od1), 32'd0);
    check("rst_err_sat", 32'({oe1, os1}), 32'd0);
    @(negedge clk);
    iv1 = 1'b0; iv2 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 32'({ov1, ir1}), 32'b01);

    // log2 basics
    do_op("l2_1",    24'h000100, 2'd0, 16'h0000, 1'b0, 1'b0, 0);
    do_op("l2_2",    24'h000200, 2'd0, 16'h0100, 1'b0, 1'b0, 0);
    do_op("l2_half", 24'h000080, 2'd0, 16'hFF00, 1'b0, 1'b0, 0);
    do_op("l2_1p5",  24'h000180, 2'd0, 16'h0095, 1'b0, 1'b0, 0);
    do_op("l2_3",    24'h000300, 2'd0, 16'h0195, 1'b0, 1'b0, 0);
    do_op("mode3",   24'h000200, 2'd3, 16'h0100, 1'b0, 1'b0, 0);
    // ln / log10
    do_op("ln_2",    24'h000200, 2'd1, 16'h00B1, 1'b0, 1'b0, 0);
    do_op("lg_2",    24'h000200, 2'd2, 16'h004D, 1'b0, 1'b0, 0);
    do_op("ln_half", 24'h000080, 2'd1, 16'hFF4E, 1'b0, 1'b0, 0);
    // boundaries
    do_op("zero",    24'h000000, 2'd0, 16'h8000, 1'b1, 1'b0, 0);
    do_op("zero_ln", 24'h000000, 2'd1, 16'h8000, 1'b1, 1'b0, 0);
    do_op("max",     24'hFFFFFF, 2'd0, 16'h0FFF, 1'b0, 1'b0, 0);
    // backpressure
    do_op("bp",      24'h000200, 2'd0, 16'h0100, 1'b0, 1'b0, 5);
    // powers of two across the whole input range and all modes
    for (int n = 0; n < 24; n += 3) begin
      for (int m = 0; m < 3; m++) begin
        do_op("pow2", 24'(1) << n, 2'(m), pow2_exp(n, 2'(m)), 1'b0, 1'b0, 0);
      end
    end

    // reset in the middle of ITER
    @(negedge clk);
    set_in(1'b1, 24'h000300, 2'd1);
    @(posedge clk); #1;
    set_in(1'b0, 24'h0, 2'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_state", 32'({ov1, ir1}), 32'b01);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_out", 32'(ov1), 32'd0);
    do_op("after_rst", 24'h000200, 2'd0, 16'h0100, 1'b0, 1'b0, 0);

    // narrow instance
    sel = 1'b1;
    do_op("n_sat",  24'h008000, 2'd0, 16'h007F, 1'b0, 1'b1, 0);
    do_op("n_4",    24'h000004, 2'd0, 16'h0020, 1'b0, 1'b0, 0);
    do_op("n_1",    24'h000001, 2'd0, 16'h0000, 1'b0, 1'b0, 0);
    do_op("n_zero", 24'h000000, 2'd0, 16'h0080, 1'b1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
